alu_seq: RTL
============

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set operand and result width; legal range 4..32.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 A  input  WIDTH  operand A, sampled only on an input handshake.
REQ-005 B  input  WIDTH  operand B, sampled only on an input handshake.
REQ-006 OP  input  3  operation select, sampled only on an input handshake.
REQ-007 in_valid  input  1  the A/B/OP request is valid.
REQ-008 in_ready  output  1  the block accepts a request this cycle.
REQ-009 Out  output  WIDTH  result, low word.
REQ-010 Hi  output  WIDTH  MUL high word; zero for all other ops.
REQ-011 Extra  output  1  carry / borrow / shifted-out bit.
REQ-012 Zero  output  1  high when {Hi,Out} is all zeros.
REQ-013 out_valid  output  1  Out/Hi/Extra/Zero are valid.
REQ-014 out_ready  input  1  the consumer takes the result this cycle.

Function
REQ-015 Input handshake SHALL occur on an edge where in_valid and in_ready are both high; output handshake SHALL occur on an edge where out_valid and out_ready are both high.
REQ-016 OP encoding SHALL be: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 MUL, 110 SHL, 111 SHR.
REQ-017 ADD SHALL set Out=(A+B) mod 2^WIDTH and Extra=carry out.
REQ-018 SUB SHALL set Out=(A-B) mod 2^WIDTH and Extra=1 iff A<B unsigned (borrow).
REQ-019 AND/OR/XOR SHALL be bitwise, with Extra=0.
REQ-020 MUL SHALL be unsigned, giving {Hi,Out}=A*B (2*WIDTH bits), with Extra=0, computed by iterative shift-add with one partial product per cycle.
REQ-021 SHL/SHR SHALL shift A logically by s=B mod WIDTH; Extra SHALL be the last bit shifted out, or 0 when s=0.
REQ-022 FSM states SHALL be IDLE, BUSY and DONE.
REQ-023 IDLE: in_ready=1, out_valid=0; a handshake with a non-MUL op SHALL register the result and go to DONE; with MUL it SHALL go to BUSY with the iteration counter at 0.
REQ-024 BUSY: in_ready=0, out_valid=0; each edge SHALL process one multiplier bit; after WIDTH iterations it SHALL go to DONE.
REQ-025 DONE: out_valid=1 and outputs SHALL be held stable until the output handshake.
REQ-026 DONE: in_ready SHALL equal out_ready, so a new request can be accepted on the same edge the result is consumed.
REQ-027 DONE with output handshake and no input handshake SHALL go to IDLE.
REQ-028 DONE with output handshake and simultaneous input handshake SHALL load the new request as from IDLE, with no bubble.
REQ-029 Latency: a non-MUL result SHALL have out_valid high 1 edge after acceptance.
REQ-030 Latency: a MUL result SHALL have out_valid high WIDTH+1 edges after acceptance.
REQ-031 in_valid and A/B/OP changes while BUSY or DONE (without handshake) SHALL have no effect.
REQ-032 A stalled consumer (out_ready=0) SHALL hold DONE indefinitely with no loss or corruption of the result.
REQ-033 Outputs SHALL be registered; no combinational path from A/B/OP to Out/Hi/Extra/Zero.
REQ-034 The only combinational input-to-output path SHALL be out_ready to in_ready.

Reset
REQ-035 rst high SHALL force IDLE, set Out=0, Hi=0, Extra=0, Zero=0, out_valid=0, and clear the iteration counter and partial product; in_ready SHALL be 1 in the cycle after reset.
REQ-036 rst SHALL take priority over any handshake on the same edge.
REQ-037 rst during BUSY or DONE SHALL abort the operation and discard the result; no out_valid pulse SHALL follow.

Verification (WIDTH=8)
REQ-038 ADD A=200, B=100, out_ready=1 -> 1 edge later: out_valid=1, Out=44, Extra=1, Zero=0.
REQ-039 SUB A=3, B=4 -> Out=255, Extra=1; SUB A=5, B=5 -> Out=0, Extra=0, Zero=1.
REQ-040 MUL A=255, B=255 -> out_valid after exactly 9 edges, {Hi,Out}=0xFE01, in_ready=0 throughout BUSY.
REQ-041 SHL A=0x81, B=1 -> Out=0x02, Extra=1; SHR A=0x81, B=9 (s=1) -> Out=0x40, Extra=1; SHL with B=8 (s=0) -> Out=A, Extra=0.
REQ-042 out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0; then raise out_ready with in_valid=1 carrying XOR 0xF0,0xFF -> back-to-back: next result Out=0x0F on the following edge.
REQ-043 MUL accepted, rst pulsed 3 edges later -> IDLE, all outputs zero, no out_valid before the next request.

Source files
------------

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq -- sequential ALU with valid/ready handshakes on both sides.
//
// Non-MUL operations finish on the acceptance edge. MUL is an unsigned
// shift-add that handles one multiplier bit per clock. All result outputs
// come from registers. The only combinational input-to-output path is from
// out_ready to in_ready. This path lets a new request be accepted on the
// same edge that the previous result is consumed.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   A, B       operands (WIDTH bits), sampled on an input handshake
//   OP         operation select (3 bits), sampled on an input handshake
//   in_valid   request valid
//   in_ready   block can accept a request this cycle
//   Out        result low word
//   Hi         MUL high word, zero for other operations
//   Extra      carry / borrow / last shifted-out bit
//   Zero       {Hi,Out} is all zeros
//   out_valid  result outputs are valid
//   out_ready  consumer takes the result this cycle
// -----------------------------------------------------------------------------
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       OP,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] Out,
  output logic [WIDTH-1:0] Hi,
  output logic             Extra,
  output logic             Zero,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] W_VAL     = WIDTH'(WIDTH);
  localparam logic [CW-1:0]    LAST_ITER = CW'(WIDTH - 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]         state_r;
  logic [WIDTH-1:0]   out_r;
  logic [WIDTH-1:0]   hi_r;
  logic               extra_r;
  logic               zero_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [2*WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0]   mplier_r;
  logic [CW-1:0]      cnt_r;

  logic [WIDTH-1:0]   shamt_s;
  logic [WIDTH:0]     add_s;
  logic [WIDTH:0]     sub_s;
  logic [WIDTH:0]     shl_s;
  logic [WIDTH:0]     shr_s;
  logic [WIDTH-1:0]   res_lo_s;
  logic               res_ex_s;
  logic [2*WIDTH-1:0] acc_next_s;
  logic               load_s;

  // Handshake signals. in_ready follows out_ready in DONE so that results can be issued back-to-back.
  always_comb begin
    in_ready  = (state_r == IDLE) || ((state_r == DONE) && out_ready);
    out_valid = (state_r == DONE);
    load_s    = in_valid && in_ready;
  end

  // Single-cycle datapath for every operation except MUL.
  always_comb begin
    shamt_s  = B % W_VAL;
    add_s    = {1'b0, A} + {1'b0, B};
    sub_s    = {1'b0, A} - {1'b0, B};
    // The extra guard bit on each shift holds the last bit shifted out.
    shl_s    = {1'b0, A} << shamt_s;
    shr_s    = {A, 1'b0} >> shamt_s;
    res_lo_s = {WIDTH{1'b0}};
    res_ex_s = 1'b0;
    case (OP)
      OP_ADD: begin
        res_lo_s = add_s[WIDTH-1:0];
        res_ex_s = add_s[WIDTH];
      end
      OP_SUB: begin
        res_lo_s = sub_s[WIDTH-1:0];
        res_ex_s = sub_s[WIDTH];
      end
      OP_AND: res_lo_s = A & B;
      OP_OR:  res_lo_s = A | B;
      OP_XOR: res_lo_s = A ^ B;
      OP_SHL: begin
        res_lo_s = shl_s[WIDTH-1:0];
        res_ex_s = (shamt_s == {WIDTH{1'b0}}) ? 1'b0 : shl_s[WIDTH];
      end
      OP_SHR: begin
        res_lo_s = shr_s[WIDTH:1];
        res_ex_s = (shamt_s == {WIDTH{1'b0}}) ? 1'b0 : shr_s[0];
      end
      default: begin
        res_lo_s = {WIDTH{1'b0}};
        res_ex_s = 1'b0;
      end
    endcase
  end

  // Shift-add step: add the shifted multiplicand when the current multiplier bit is set.
  always_comb begin
    if (mplier_r[0]) begin
      acc_next_s = acc_r + mcand_r;
    end else begin
      acc_next_s = acc_r;
    end
  end

  // Control FSM, multiplier iteration, and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      out_r    <= {WIDTH{1'b0}};
      hi_r     <= {WIDTH{1'b0}};
      extra_r  <= 1'b0;
      zero_r   <= 1'b0;
      acc_r    <= {(2*WIDTH){1'b0}};
      mcand_r  <= {(2*WIDTH){1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      cnt_r    <= {CW{1'b0}};
    end else if (load_s) begin
      // The same request load path is used from IDLE and from a consumed DONE.
      if (OP == OP_MUL) begin
        state_r  <= BUSY;
        acc_r    <= {(2*WIDTH){1'b0}};
        mcand_r  <= {{WIDTH{1'b0}}, A};
        mplier_r <= B;
        cnt_r    <= {CW{1'b0}};
      end else begin
        state_r <= DONE;
        out_r   <= res_lo_s;
        hi_r    <= {WIDTH{1'b0}};
        extra_r <= res_ex_s;
        zero_r  <= (res_lo_s == {WIDTH{1'b0}});
      end
    end else begin
      case (state_r)
        IDLE: state_r <= IDLE;
        BUSY: begin
          acc_r    <= acc_next_s;
          mcand_r  <= {mcand_r[2*WIDTH-2:0], 1'b0};
          mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
          cnt_r    <= cnt_r + CW'(1);
          if (cnt_r == LAST_ITER) begin
            state_r <= DONE;
            out_r   <= acc_next_s[WIDTH-1:0];
            hi_r    <= acc_next_s[2*WIDTH-1:WIDTH];
            extra_r <= 1'b0;
            zero_r  <= (acc_next_s == {(2*WIDTH){1'b0}});
          end else begin
            state_r <= BUSY;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign Out   = out_r;
  assign Hi    = hi_r;
  assign Extra = extra_r;
  assign Zero  = zero_r;

endmodule
